// File: rtl/gpio_in_filter_pkg.sv
// gpio_in_filter shared types: register offsets and bus decode.
// Offsets are the same ones the gpio peripheral uses.
package gpio_in_filter_pkg;

  localparam logic [7:0] ADDR_LIMIT = 8'h00;
  localparam logic [7:0] ADDR_STATE = 8'h04;
  localparam logic [7:0] ADDR_RAW   = 8'h08;
  localparam logic [7:0] ADDR_RISE  = 8'h0C;
  localparam logic [7:0] ADDR_FALL  = 8'h10;
  localparam logic [7:0] ADDR_PEND  = 8'h14;

  typedef enum logic [2:0] {
    REG_LIMIT,
    REG_STATE,
    REG_RAW,
    REG_RISE,
    REG_FALL,
    REG_PEND,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode(
    input logic [7:0] a
  );
    reg_sel_e r;
    unique case (1'b1)
      (a == ADDR_LIMIT): r = REG_LIMIT;
      (a == ADDR_STATE): r = REG_STATE;
      (a == ADDR_RAW):   r = REG_RAW;
      (a == ADDR_RISE):  r = REG_RISE;
      (a == ADDR_FALL):  r = REG_FALL;
      (a == ADDR_PEND):  r = REG_PEND;
      default:           r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_in_filter_if.sv
// Peripheral bus: address, write_data, we, re (master drives),
// read_data (slave drives, combinational).
interface gpio_in_filter_if;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;

  modport master (
    output address, write_data, we, re,
    input  read_data
  );

  modport slave (
    input  address, write_data, we, re,
    output read_data
  );
endinterface

// File: rtl/gpio_debounce_cell.sv
// One pin's debounce counter and clean flop.
// Ports: clk, rst_n, sync (synced pin), limit, clean, clean_nxt.
module gpio_debounce_cell #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic [CNT_W-1:0] limit,
  output logic             clean,
  output logic             clean_nxt
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // >= lets a lowered limit fire at once and keeps cnt <= limit
  always_comb begin
    clean_nxt = clean;
    cnt_nxt   = cnt + 1'b1;
    if (sync == clean) begin
      cnt_nxt = '0;
    end else if (cnt >= limit) begin
      clean_nxt = sync;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean <= 1'b0;
      cnt   <= '0;
    end else begin
      clean <= clean_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-flop sync, optional per-pin debounce
// (GPIO_IN_FILTER_DEBOUNCE_EN), edge capture into W1C PENDING, irq.
// Ports: clk, rst_n, bus (slave), pins_async, pins_clean, irq.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int N_PINS = 8,
  parameter int CNT_W  = 16,
  parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(1000)
) (
  input  logic              clk,
  input  logic              rst_n,
  gpio_in_filter_if.slave   bus,
  input  logic [N_PINS-1:0] pins_async,
  output logic [N_PINS-1:0] pins_clean,
  output logic              irq
);

  reg_sel_e sel;

  logic [N_PINS-1:0] sync1;
  logic [N_PINS-1:0] sync2;
  logic [N_PINS-1:0] clean;
  logic [N_PINS-1:0] clean_nxt;
  logic [N_PINS-1:0] rise_en;
  logic [N_PINS-1:0] fall_en;
  logic [N_PINS-1:0] pending;
  logic [N_PINS-1:0] set;
  logic [N_PINS-1:0] clr;
  logic [N_PINS-1:0] wr_pins;

  logic unused_ok;
  assign unused_ok = ^{1'b0, bus.re, bus.write_data};

  assign sel     = decode(bus.address);
  assign wr_pins = bus.write_data[N_PINS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins_async;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_IN_FILTER_DEBOUNCE_EN
  logic [CNT_W-1:0] limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit <= DEFAULT_LIMIT;
    end else if (bus.we && sel == REG_LIMIT) begin
      limit <= bus.write_data[CNT_W-1:0];
    end
  end

  for (genvar i = 0; i < N_PINS; i++) begin : g_cell
    gpio_debounce_cell #(
      .CNT_W (CNT_W)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .sync      (sync2[i]),
      .limit     (limit),
      .clean     (clean[i]),
      .clean_nxt (clean_nxt[i])
    );
  end
`else
  assign clean_nxt = sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean <= '0;
    end else begin
      clean <= clean_nxt;
    end
  end
`endif

  // edges seen on clean_nxt so PENDING sets with pins_clean
  assign set = (clean_nxt & ~clean & rise_en)
             | (~clean_nxt & clean & fall_en);

  assign clr = (bus.we && sel == REG_PEND) ? wr_pins : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_en <= '0;
      fall_en <= '0;
      pending <= '0;
    end else begin
      if (bus.we && sel == REG_RISE) rise_en <= wr_pins;
      if (bus.we && sel == REG_FALL) fall_en <= wr_pins;
      // set wins over a same-cycle clear
      pending <= (pending & ~clr) | set;
    end
  end

  always_comb begin
    bus.read_data = '0;
    case (sel)
`ifdef GPIO_IN_FILTER_DEBOUNCE_EN
      REG_LIMIT: bus.read_data[CNT_W-1:0] = limit;
`endif
      REG_STATE: bus.read_data[N_PINS-1:0] = clean;
      REG_RAW:   bus.read_data[N_PINS-1:0] = sync2;
      REG_RISE:  bus.read_data[N_PINS-1:0] = rise_en;
      REG_FALL:  bus.read_data[N_PINS-1:0] = fall_en;
      REG_PEND:  bus.read_data[N_PINS-1:0] = pending;
      default:   bus.read_data = '0;
    endcase
  end

  assign pins_clean = clean;
  assign irq        = |pending;

endmodule
